// File: rtl/cca_pkg.sv
// Shared constants for the clear-channel assessment block: busy_reason bit map and
// the counter-width helper used to size cycle and microsecond counters.
package cca_pkg;

    localparam int unsigned BR_PHYS  = 0;
    localparam int unsigned BR_NAV   = 1;
    localparam int unsigned BR_TX    = 2;
    localparam int unsigned BR_WAD   = 3;
    localparam int unsigned BR_WIDTH = 4;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cca_us_timer.sv
// Microsecond down-counter: a cycle prescaler ticks the count down to zero; a load only
// ever lengthens the remaining time, and clear wins over everything.
module cca_us_timer
    import cca_pkg::*;
#(
    parameter int unsigned CYCLES_PER_US = 100,
    parameter int unsigned WIDTH         = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] remaining_o,
    output logic             active_o
);

    localparam int unsigned    PW       = cnt_width(CYCLES_PER_US - 1);
    localparam logic [PW-1:0]  PRE_LAST = PW'(CYCLES_PER_US - 1);

    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    always_comb begin
        pre_d = pre_q;
        rem_d = rem_q;
        if (clear_i) begin
            pre_d = '0;
            rem_d = '0;
        end else if (load_i && (load_val_i > rem_q)) begin
            pre_d = '0;
            rem_d = load_val_i;
        end else if (rem_q != '0) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                rem_d = rem_q - 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end else begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pre_q <= '0;
            rem_q <= '0;
        end else begin
            pre_q <= pre_d;
            rem_q <= rem_d;
        end
    end

    assign remaining_o = rem_q;
    assign active_o    = (rem_q != '0);

endmodule

// File: rtl/cca_nav.sv
// Clear-channel assessment: masked multi-antenna energy detect with busy hysteresis,
// a wait-after-decode idle override, NAV virtual carrier sense and own-tx gating.
module cca_nav
    import cca_pkg::*;
#(
    parameter int unsigned RSSI_HALF_DB_WIDTH = 11,
    parameter int unsigned NUM_ANT            = 2,
    parameter int unsigned CYCLES_PER_US      = 100,
    parameter int unsigned NAV_WIDTH          = 16
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [NUM_ANT*RSSI_HALF_DB_WIDTH-1:0] rssi_half_db_i,
    input  logic [RSSI_HALF_DB_WIDTH-1:0]         rssi_half_db_th_i,
    input  logic [NUM_ANT-1:0]                    ant_mask_i,
    input  logic [7:0]                            busy_hold_top_i,
    input  logic                                  demod_is_ongoing_i,
    input  logic                                  tx_rf_is_ongoing_i,
    input  logic                                  cts_toself_rf_is_ongoing_i,
    input  logic                                  ack_cts_is_ongoing_i,
    input  logic                                  fcs_in_strobe_i,
    input  logic [7:0]                            wait_after_decode_top_i,
    input  logic                                  nav_update_strobe_i,
    input  logic [NAV_WIDTH-1:0]                  nav_duration_i,
    input  logic                                  nav_reset_strobe_i,
    output logic                                  ch_idle_o,
    output logic                                  ch_idle_rssi_o,
    output logic                                  nav_active_o,
    output logic [NAV_WIDTH-1:0]                  nav_remaining_us_o,
    output logic [BR_WIDTH-1:0]                   busy_reason_o
);

    localparam int unsigned TW = cnt_width(255 * CYCLES_PER_US);

    logic          ed_busy_q, ed_busy_d;
    logic [TW-1:0] hold_top_q, hold_top_d;
    logic [TW-1:0] hold_cnt_q, hold_cnt_d;
    logic [TW-1:0] wad_top_q, wad_top_d;
    logic [TW-1:0] wad_cnt_q, wad_cnt_d;
    logic          wad_on_q, wad_on_d;
    logic          phys_raw, phys_busy, tx_any;

    assign hold_top_d = TW'(32'(busy_hold_top_i) * CYCLES_PER_US);
    assign wad_top_d  = TW'(32'(wait_after_decode_top_i) * CYCLES_PER_US);

    always_comb begin
        ed_busy_d = 1'b0;
        for (int k = 0; k < int'(NUM_ANT); k++) begin
            if (ant_mask_i[k] &&
                (rssi_half_db_i[k*RSSI_HALF_DB_WIDTH +: RSSI_HALF_DB_WIDTH] > rssi_half_db_th_i)) begin
                ed_busy_d = 1'b1;
            end
        end
    end

    assign phys_raw  = ed_busy_q | demod_is_ongoing_i;
    assign phys_busy = phys_raw | (hold_cnt_q != '0);
    assign tx_any    = tx_rf_is_ongoing_i | cts_toself_rf_is_ongoing_i | ack_cts_is_ongoing_i;

    // Hysteresis is suppressed while the post-decode override is running.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (wad_on_q) begin
            hold_cnt_d = '0;
        end else if (phys_raw) begin
            hold_cnt_d = hold_top_q;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
        end
    end

    always_comb begin
        wad_on_d  = wad_on_q;
        wad_cnt_d = wad_cnt_q;
        if (fcs_in_strobe_i && (wad_top_q != '0)) begin
            wad_on_d  = 1'b1;
            wad_cnt_d = '0;
        end else if (wad_on_q) begin
            if (wad_cnt_q >= wad_top_q) begin
                wad_on_d = 1'b0;
            end else begin
                wad_cnt_d = wad_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ed_busy_q  <= 1'b0;
            hold_top_q <= '0;
            hold_cnt_q <= '0;
            wad_top_q  <= '0;
            wad_cnt_q  <= '0;
            wad_on_q   <= 1'b0;
        end else begin
            ed_busy_q  <= ed_busy_d;
            hold_top_q <= hold_top_d;
            hold_cnt_q <= hold_cnt_d;
            wad_top_q  <= wad_top_d;
            wad_cnt_q  <= wad_cnt_d;
            wad_on_q   <= wad_on_d;
        end
    end

    // Durations with the MSB set are not valid NAV values and are dropped.
    cca_us_timer #(
        .CYCLES_PER_US(CYCLES_PER_US),
        .WIDTH        (NAV_WIDTH)
    ) u_nav_timer (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (nav_update_strobe_i & ~nav_duration_i[NAV_WIDTH-1]),
        .load_val_i (nav_duration_i),
        .clear_i    (nav_reset_strobe_i),
        .remaining_o(nav_remaining_us_o),
        .active_o   (nav_active_o)
    );

    always_comb begin
        ch_idle_rssi_o         = wad_on_q | ~phys_busy;
        ch_idle_o              = ch_idle_rssi_o & ~nav_active_o & ~tx_any;
        busy_reason_o          = '0;
        busy_reason_o[BR_PHYS] = phys_busy;
        busy_reason_o[BR_NAV]  = nav_active_o;
        busy_reason_o[BR_TX]   = tx_any;
        busy_reason_o[BR_WAD]  = wad_on_q;
    end

endmodule
